siw_agu_1: RTL and testbench

Address generation unit driving one port of a dual-port SIW block-RAM wrapper. After a start pulse, it issues a programmable sequence of strided accesses: enable, address and write-enable, with a configurable start delay and issue period. All outputs are registered and feed the memory port's enable, write_en and address inputs directly. A stall input lets the datapath freeze the sequence, and a one-cycle done pulse hands control back to the sequencer.

---
 rtl/siw_agu_1.sv | 145 ++++++++++++++
 tb/tb_siw_agu_1.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/siw_agu_1.sv
// Strided address generator for one port of the SIW dual-port block RAM.
// Issues count accesses (start + k*stride) after a start delay, spaced by period idle cycles.
module siw_agu_1 (
    input  logic        siw_agu_1_clk,
    input  logic        siw_agu_1_reset,
    input  logic        siw_agu_1_init,
    input  logic        siw_agu_1_run,
    input  logic        siw_agu_1_stall,
    input  logic        siw_agu_1_wr_mode,
    input  logic [9:0]  siw_agu_1_start,
    input  logic [9:0]  siw_agu_1_stride,
    input  logic [10:0] siw_agu_1_count,
    input  logic [7:0]  siw_agu_1_delay,
    input  logic [3:0]  siw_agu_1_period,
    output logic        siw_agu_1_enable,
    output logic        siw_agu_1_write_en,
    output logic [9:0]  siw_agu_1_address,
    output logic        siw_agu_1_busy,
    output logic        siw_agu_1_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_wr_mode;
    logic [9:0]  r_stride;
    logic [3:0]  r_period;
    logic [9:0]  r_acc;
    logic [10:0] r_remain;
    logic [7:0]  r_dcnt;
    logic [3:0]  r_pcnt;
    logic        r_done_req;

    logic        r_enable;
    logic        r_write_en;
    logic [9:0]  r_address;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_advance;
    logic        w_issue;
    logic        w_last;

    // r_busy gates acceptance so a run during the final access cycle is ignored like any other busy run.
    assign w_accept  = (r_state == S_IDLE) && !r_busy && siw_agu_1_run &&
                       !siw_agu_1_stall && !siw_agu_1_init;
    assign w_advance = !siw_agu_1_stall && !siw_agu_1_init;
    assign w_issue   = (r_state == S_RUN) && w_advance && (r_pcnt == 4'd0);
    assign w_last    = w_issue && (r_remain == 11'd1);

    always_ff @(posedge siw_agu_1_clk or negedge siw_agu_1_reset) begin
        if (!siw_agu_1_reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: every register uses <= so all flops sample the same pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        if (siw_agu_1_init) begin
            w_state_nxt = S_IDLE;
        end else if (!siw_agu_1_stall) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (siw_agu_1_count == 11'd0)
                            w_state_nxt = S_IDLE;
                        else if (siw_agu_1_delay == 8'd0)
                            w_state_nxt = S_RUN;
                        else
                            w_state_nxt = S_DELAY;
                    end
                end
                S_DELAY: if (r_dcnt == 8'd1) w_state_nxt = S_RUN;
                S_RUN:   if (w_last) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge siw_agu_1_clk or negedge siw_agu_1_reset) begin
        if (!siw_agu_1_reset) begin
            r_wr_mode  <= 1'b0;
            r_stride   <= '0;
            r_period   <= '0;
            r_acc      <= '0;
            r_remain   <= '0;
            r_dcnt     <= '0;
            r_pcnt     <= '0;
            r_done_req <= 1'b0;
            r_enable   <= 1'b0;
            r_write_en <= 1'b0;
            r_address  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_enable   <= w_issue;
            r_write_en <= w_issue & r_wr_mode;
            r_busy     <= !siw_agu_1_init && (r_state != S_IDLE);
            r_done     <= !siw_agu_1_init && r_done_req;
            r_done_req <= (w_accept && (siw_agu_1_count == 11'd0)) || w_last;

            if (w_accept) begin
                r_wr_mode <= siw_agu_1_wr_mode;
                r_stride  <= siw_agu_1_stride;
                r_period  <= siw_agu_1_period;
                r_acc     <= siw_agu_1_start;
                r_remain  <= siw_agu_1_count;
                r_dcnt    <= siw_agu_1_delay;
                r_pcnt    <= 4'd0;
            end

            if ((r_state == S_DELAY) && w_advance)
                r_dcnt <= r_dcnt - 8'd1;

            if ((r_state == S_RUN) && w_advance) begin
                if (r_pcnt == 4'd0) begin
                    r_address <= r_acc;
                    r_acc     <= r_acc + r_stride;
                    r_remain  <= r_remain - 11'd1;
                    r_pcnt    <= r_period;
                end else begin
                    r_pcnt <= r_pcnt - 4'd1;
                end
            end
        end
    end

    assign siw_agu_1_enable   = r_enable;
    assign siw_agu_1_write_en = r_write_en;
    assign siw_agu_1_address  = r_address;
    assign siw_agu_1_busy     = r_busy;
    assign siw_agu_1_done     = r_done;

endmodule

// File: tb/tb_siw_agu_1.sv
// Scoreboard bench for siw_agu_1: expected accesses and done pulses are queued at run time
// from the access timing formula and compared as the DUT emits them.
module tb_siw_agu_1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        wr_mode = 1'b0;
    logic [9:0]  start = '0;
    logic [9:0]  stride = '0;
    logic [10:0] count = '0;
    logic [7:0]  delay = '0;
    logic [3:0]  period = '0;

    logic        enable;
    logic        write_en;
    logic [9:0]  address;
    logic        busy;
    logic        done;

    siw_agu_1 dut (
        .siw_agu_1_clk      (clk),
        .siw_agu_1_reset    (rst_n),
        .siw_agu_1_init     (init),
        .siw_agu_1_run      (run),
        .siw_agu_1_stall    (stall),
        .siw_agu_1_wr_mode  (wr_mode),
        .siw_agu_1_start    (start),
        .siw_agu_1_stride   (stride),
        .siw_agu_1_count    (count),
        .siw_agu_1_delay    (delay),
        .siw_agu_1_period   (period),
        .siw_agu_1_enable   (enable),
        .siw_agu_1_write_en (write_en),
        .siw_agu_1_address  (address),
        .siw_agu_1_busy     (busy),
        .siw_agu_1_done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic       we;
    } acc_t;

    acc_t          exp_q[$];
    int            done_q[$];
    int            bz_lo = 1;
    int            bz_hi = 0;
    bit            mon_en = 1'b0;
    logic [1023:0] seen_map = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'd0, busy}, {31'd0, (cyc >= bz_lo) && (cyc <= bz_hi)});
            if (enable) begin
                seen_map[address] = 1'b1;
                if (exp_q.size() == 0) begin
                    check("spurious_enable", 32'd1, 32'd0);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check("acc_cycle", cyc, e.cyc);
                    check("acc_addr", {22'd0, address}, {22'd0, e.addr});
                    check("acc_we", {31'd0, write_en}, {31'd0, e.we});
                end
            end else if (write_en) begin
                check("we_without_enable", 32'd1, 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0)
                    check("spurious_done", 32'd1, 32'd0);
                else
                    check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Called #1 after a rising edge; run is sampled at the next edge (t0).
    task automatic start_seq(input logic [9:0] s, input logic [9:0] st, input logic [10:0] n,
                             input logic [7:0] d, input logic [3:0] p, input logic wm,
                             output int t0);
        acc_t e;
        int   tdone;
        start = s; stride = st; count = n; delay = d; period = p; wr_mode = wm; run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        t0 = cyc;
        for (int k = 0; k < int'(n); k++) begin
            e.cyc  = t0 + int'(d) + 1 + k * (int'(p) + 1);
            e.addr = 10'(int'(s) + k * int'(st));
            e.we   = wm;
            exp_q.push_back(e);
        end
        tdone = (n == 11'd0) ? t0 + 1 : t0 + int'(d) + 1 + (int'(n) - 1) * (int'(p) + 1) + 1;
        done_q.push_back(tdone);
        bz_lo = t0 + 1;
        bz_hi = tdone - 1;
    endtask

    // A stall sampled at edge `from` postpones every later event by one cycle.
    task automatic shift_from(input int from);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].cyc >= from) exp_q[i].cyc = exp_q[i].cyc + 1;
        for (int i = 0; i < done_q.size(); i++)
            if (done_q[i] >= from) done_q[i] = done_q[i] + 1;
        if (bz_hi >= from) bz_hi = bz_hi + 1;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (((exp_q.size() != 0) || (done_q.size() != 0)) && (i < budget)) begin
            @(posedge clk);
            i++;
        end
        if ((exp_q.size() != 0) || (done_q.size() != 0))
            check("drain_timeout", exp_q.size() + done_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        acc_t tmp;

        #1;
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_address", {22'd0, address}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic read
        start_seq(10'h010, 10'd1, 11'd4, 8'd0, 4'd0, 1'b0, t0);
        drain(20);

        // Wrap with negative stride, delay and period
        start_seq(10'h3FE, 10'h3FF, 11'd4, 8'd2, 4'd1, 1'b0, t0);
        drain(30);

        // Write sequence wrapping, stall over the second access
        start_seq(10'h3FE, 10'd2, 11'd3, 8'd0, 4'd0, 1'b1, t0);
        @(posedge clk);
        #1;
        stall = 1'b1;
        shift_from(t0 + 2);
        @(posedge clk);
        #1;
        stall = 1'b0;
        drain(20);

        // count = 0: done only
        start_seq(10'h055, 10'd1, 11'd0, 8'd3, 4'd2, 1'b1, t0);
        drain(10);

        // run while busy is ignored
        start_seq(10'h100, 10'd7, 11'd6, 8'd1, 4'd1, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;
        start = 10'h200; stride = 10'd3; count = 11'd2; delay = 8'd0; period = 4'd0;
        wr_mode = 1'b0; run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        drain(40);

        // init mid-RUN aborts without done
        start_seq(10'h020, 10'd1, 11'd20, 8'd0, 4'd0, 1'b0, t0);
        repeat (3) @(posedge clk);
        #1;
        init = 1'b1;
        while ((exp_q.size() != 0) && (exp_q[exp_q.size() - 1].cyc >= t0 + 4))
            tmp = exp_q.pop_back();
        done_q.delete();
        bz_hi = t0 + 3;
        @(posedge clk);
        #1;
        init = 1'b0;
        drain(10);

        // init overrides a simultaneous run
        start = 10'h111; stride = 10'd1; count = 11'd3; delay = 8'd0; period = 4'd0;
        run = 1'b1; init = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0; init = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back: second run issued in the done cycle
        start_seq(10'h0AA, 10'h010, 11'd2, 8'd0, 4'd0, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        start_seq(10'h300, 10'h3FF, 11'd3, 8'd1, 4'd0, 1'b0, t0);
        drain(20);

        // count = 1024 covers every address once
        seen_map = '0;
        start_seq(10'h155, 10'd1, 11'd1024, 8'd0, 4'd0, 1'b0, t0);
        drain(1100);
        check("full_coverage", $countones(seen_map), 32'd1024);

        // Asynchronous reset mid-run, then 20 quiet cycles
        start_seq(10'h001, 10'd1, 11'd50, 8'd0, 4'd1, 1'b1, t0);
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_enable", {31'd0, enable}, 32'd0);
        check("midrst_write_en", {31'd0, write_en}, 32'd0);
        check("midrst_address", {22'd0, address}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        done_q.delete();
        bz_lo = 1;
        bz_hi = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_enable", {31'd0, enable}, 32'd0);
            check("idle_address", {22'd0, address}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;

        check("final_queues", exp_q.size() + done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
